// File: rtl/cache_assoc_wb.sv
// Two-way set-associative write-back / write-allocate cache with a one-beat-at-a-time
// memory port. Hits answer in one cycle from IDLE; misses go through WRITEBACK/REFILL/RESPOND.
module cache_assoc_wb #(
    parameter int LOG_NUM_SETS   = 2,
    parameter int LOG_NUM_BLOCKS = 1,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  mem_req_valid,
    output logic                  mem_req_write,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    output logic [DATA_WIDTH-1:0] mem_req_wdata,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
    output logic [CNT_WIDTH-1:0]  hit_count,
    output logic [CNT_WIDTH-1:0]  miss_count
);
    localparam int NUM_SETS  = 1 << LOG_NUM_SETS;
    localparam int TAG_W     = ADDR_WIDTH - LOG_NUM_SETS - LOG_NUM_BLOCKS;
    localparam int IDX_W     = LOG_NUM_SETS + LOG_NUM_BLOCKS;
    localparam int NUM_WORDS = 1 << IDX_W;
    localparam logic [LOG_NUM_BLOCKS-1:0] OFF_ZERO  = {LOG_NUM_BLOCKS{1'b0}};
    localparam logic [LOG_NUM_BLOCKS-1:0] BEAT_LAST = {LOG_NUM_BLOCKS{1'b1}};
    localparam logic [LOG_NUM_BLOCKS-1:0] BEAT_ONE  = {{(LOG_NUM_BLOCKS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_RESPOND   = 2'd3
    } state_e;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    state_e                               state_q, state_d;
    logic [ADDR_WIDTH-1:0]                addr_q, addr_d;
    logic [DATA_WIDTH-1:0]                wdata_q, wdata_d;
    logic                                 write_q, write_d;
    logic                                 victim_q, victim_d;
    logic [LOG_NUM_BLOCKS-1:0]            beat_q, beat_d;
    logic [1:0][NUM_SETS-1:0]             valid_q, valid_d;
    logic [1:0][NUM_SETS-1:0]             dirty_q, dirty_d;
    logic [1:0][NUM_SETS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [NUM_SETS-1:0]                  lru_q, lru_d;
    logic                                 req_ready_q, req_ready_d;
    logic                                 resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]                resp_rdata_q, resp_rdata_d;
    logic                                 mem_req_valid_q, mem_req_valid_d;
    logic                                 mem_req_write_q, mem_req_write_d;
    logic [ADDR_WIDTH-1:0]                mem_req_addr_q, mem_req_addr_d;
    logic [DATA_WIDTH-1:0]                mem_req_wdata_q, mem_req_wdata_d;
    logic [CNT_WIDTH-1:0]                 hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]                 miss_cnt_q, miss_cnt_d;

    logic [DATA_WIDTH-1:0]                data_q [2][NUM_WORDS];
    logic                                 data_we_s;
    logic                                 data_way_s;
    logic [IDX_W-1:0]                     data_idx_s;
    logic [DATA_WIDTH-1:0]                data_wr_s;

    logic [LOG_NUM_SETS-1:0]   req_set_s, cur_set_s;
    logic [TAG_W-1:0]          req_tag_s, cur_tag_s;
    logic [IDX_W-1:0]          req_idx_s;
    logic [LOG_NUM_BLOCKS-1:0] cur_off_s, beat_inc_s;
    logic                      hit0_s, hit1_s, hit_s, hit_way_s, victim_s;

    assign req_set_s  = req_addr[LOG_NUM_BLOCKS +: LOG_NUM_SETS];
    assign req_tag_s  = req_addr[ADDR_WIDTH-1 -: TAG_W];
    assign req_idx_s  = req_addr[IDX_W-1:0];
    assign cur_set_s  = addr_q[LOG_NUM_BLOCKS +: LOG_NUM_SETS];
    assign cur_tag_s  = addr_q[ADDR_WIDTH-1 -: TAG_W];
    assign cur_off_s  = addr_q[LOG_NUM_BLOCKS-1:0];
    assign beat_inc_s = beat_q + BEAT_ONE;

    assign hit0_s    = valid_q[0][req_set_s] && (tag_q[0][req_set_s] == req_tag_s);
    assign hit1_s    = valid_q[1][req_set_s] && (tag_q[1][req_set_s] == req_tag_s);
    assign hit_s     = hit0_s || hit1_s;
    assign hit_way_s = ~hit0_s;
    // Prefer an empty way before consulting the LRU bit.
    assign victim_s  = !valid_q[0][req_set_s] ? 1'b0 :
                       (!valid_q[1][req_set_s] ? 1'b1 : lru_q[req_set_s]);

    // Next-state and datapath decisions for lookup, writeback, refill and response.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        write_d         = write_q;
        victim_d        = victim_q;
        beat_d          = beat_q;
        valid_d         = valid_q;
        dirty_d         = dirty_q;
        tag_d           = tag_q;
        lru_d           = lru_q;
        resp_valid_d    = 1'b0;
        resp_rdata_d    = resp_rdata_q;
        mem_req_valid_d = mem_req_valid_q;
        mem_req_write_d = mem_req_write_q;
        mem_req_addr_d  = mem_req_addr_q;
        mem_req_wdata_d = mem_req_wdata_q;
        hit_cnt_d       = hit_cnt_q;
        miss_cnt_d      = miss_cnt_q;
        data_we_s       = 1'b0;
        data_way_s      = victim_q;
        data_idx_s      = {cur_set_s, beat_q};
        data_wr_s       = mem_resp_rdata;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    write_d = req_write;
                    if (hit_s) begin
                        hit_cnt_d                     = sat_inc(hit_cnt_q);
                        resp_valid_d                  = 1'b1;
                        resp_rdata_d                  = req_write ? req_wdata : data_q[hit_way_s][req_idx_s];
                        lru_d[req_set_s]              = ~hit_way_s;
                        data_we_s                     = req_write;
                        data_way_s                    = hit_way_s;
                        data_idx_s                    = req_idx_s;
                        data_wr_s                     = req_wdata;
                        dirty_d[hit_way_s][req_set_s] = dirty_q[hit_way_s][req_set_s] | req_write;
                    end else begin
                        miss_cnt_d                   = sat_inc(miss_cnt_q);
                        victim_d                     = victim_s;
                        beat_d                       = OFF_ZERO;
                        valid_d[victim_s][req_set_s] = 1'b0;
                        dirty_d[victim_s][req_set_s] = 1'b0;
                        mem_req_valid_d              = 1'b1;
                        if (valid_q[victim_s][req_set_s] && dirty_q[victim_s][req_set_s]) begin
                            state_d         = S_WRITEBACK;
                            mem_req_write_d = 1'b1;
                            mem_req_addr_d  = {tag_q[victim_s][req_set_s], req_set_s, OFF_ZERO};
                            mem_req_wdata_d = data_q[victim_s][{req_set_s, OFF_ZERO}];
                        end else begin
                            state_d         = S_REFILL;
                            mem_req_write_d = 1'b0;
                            mem_req_addr_d  = {req_tag_s, req_set_s, OFF_ZERO};
                            mem_req_wdata_d = {DATA_WIDTH{1'b0}};
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITEBACK: begin
                if (mem_req_ready) begin
                    if (beat_q == BEAT_LAST) begin
                        beat_d          = OFF_ZERO;
                        state_d         = S_REFILL;
                        mem_req_write_d = 1'b0;
                        mem_req_addr_d  = {cur_tag_s, cur_set_s, OFF_ZERO};
                        mem_req_wdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        beat_d          = beat_inc_s;
                        mem_req_addr_d  = {tag_q[victim_q][cur_set_s], cur_set_s, beat_inc_s};
                        mem_req_wdata_d = data_q[victim_q][{cur_set_s, beat_inc_s}];
                    end
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_REFILL: begin
                mem_req_valid_d = mem_req_valid_q && !mem_req_ready;
                // A response counts once its read beat has been (or is being) accepted.
                if (mem_resp_valid && (!mem_req_valid_q || mem_req_ready)) begin
                    data_we_s = 1'b1;
                    if (beat_q == BEAT_LAST) begin
                        valid_d[victim_q][cur_set_s] = 1'b1;
                        dirty_d[victim_q][cur_set_s] = 1'b0;
                        tag_d[victim_q][cur_set_s]   = cur_tag_s;
                        lru_d[cur_set_s]             = ~victim_q;
                        beat_d                       = OFF_ZERO;
                        state_d                      = S_RESPOND;
                    end else begin
                        beat_d          = beat_inc_s;
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {cur_tag_s, cur_set_s, beat_inc_s};
                    end
                end else begin
                    state_d = S_REFILL;
                end
            end
            S_RESPOND: begin
                data_we_s                    = write_q;
                data_idx_s                   = {cur_set_s, cur_off_s};
                data_wr_s                    = wdata_q;
                dirty_d[victim_q][cur_set_s] = write_q;
                resp_valid_d                 = 1'b1;
                resp_rdata_d                 = write_q ? wdata_q : data_q[victim_q][{cur_set_s, cur_off_s}];
                state_d                      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // Control, tag and output registers; async active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            addr_q          <= {ADDR_WIDTH{1'b0}};
            wdata_q         <= {DATA_WIDTH{1'b0}};
            write_q         <= 1'b0;
            victim_q        <= 1'b0;
            beat_q          <= OFF_ZERO;
            valid_q         <= '{default: 1'b0};
            dirty_q         <= '{default: 1'b0};
            tag_q           <= '{default: {TAG_W{1'b0}}};
            lru_q           <= {NUM_SETS{1'b0}};
            req_ready_q     <= 1'b1;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= {DATA_WIDTH{1'b0}};
            mem_req_valid_q <= 1'b0;
            mem_req_write_q <= 1'b0;
            mem_req_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_req_wdata_q <= {DATA_WIDTH{1'b0}};
            hit_cnt_q       <= {CNT_WIDTH{1'b0}};
            miss_cnt_q      <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            write_q         <= write_d;
            victim_q        <= victim_d;
            beat_q          <= beat_d;
            valid_q         <= valid_d;
            dirty_q         <= dirty_d;
            tag_q           <= tag_d;
            lru_q           <= lru_d;
            req_ready_q     <= req_ready_d;
            resp_valid_q    <= resp_valid_d;
            resp_rdata_q    <= resp_rdata_d;
            mem_req_valid_q <= mem_req_valid_d;
            mem_req_write_q <= mem_req_write_d;
            mem_req_addr_q  <= mem_req_addr_d;
            mem_req_wdata_q <= mem_req_wdata_d;
            hit_cnt_q       <= hit_cnt_d;
            miss_cnt_q      <= miss_cnt_d;
        end
    end

    // Line data array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (data_we_s) begin
            data_q[data_way_s][data_idx_s] <= data_wr_s;
        end
    end

    assign req_ready     = req_ready_q;
    assign resp_valid    = resp_valid_q;
    assign resp_rdata    = resp_rdata_q;
    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_write = mem_req_write_q;
    assign mem_req_addr  = mem_req_addr_q;
    assign mem_req_wdata = mem_req_wdata_q;
    assign hit_count     = hit_cnt_q;
    assign miss_count    = miss_cnt_q;
endmodule
